bcd_scan_counter: RTL

- Multi-digit successor to the single-digit manual counter.
- Counts debounced button presses, up or down, in a DIGITS-wide BCD register.
- Drives a multiplexed common-anode 7-segment bank: one digit enabled at a time, scanned from the board clock.
- Sits between raw board buttons and the display pins. Exposes the BCD value and a wrap pulse for other logic.

---
 rtl/bcd_scan_counter.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/bcd_scan_counter.sv
// bcd_scan_counter
//   Counts debounced button presses, up or down, in a DIGITS-wide BCD register.
//   It also scans the value onto a multiplexed 7-segment bank.
//
// Ports
//   clk      : board clock, all logic on posedge
//   reset    : asynchronous, active-low; clears all state
//   btn_step : raw step button, active-low, asynchronous to clk
//   btn_dir  : raw direction level, active-low (pressed = count down)
//   seg      : {dp,g,f,e,d,c,b,a} for the selected digit, polarity per ACTIVE_LOW
//   dig      : one-hot digit enable, polarity per ACTIVE_LOW
//   count    : BCD value, digit 0 in bits [3:0]
//   wrap     : one-cycle pulse when the count wraps in either direction
module bcd_scan_counter #(
  parameter int DIGITS     = 4,
  parameter int SCAN_DIV   = 6000,
  parameter int DEBOUNCE   = 240000,
  parameter int ACTIVE_LOW = 1,
  parameter int LZB        = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  btn_step,
  input  logic                  btn_dir,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     dig,
  output logic [4*DIGITS-1:0]   count,
  output logic                  wrap
);

  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE - 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  // ---------------------------------------------------------------------
  // Input path. Bit 0 = step, bit 1 = dir.
  // sync flops hold the raw (active-low) level; acc holds the accepted
  // level as active-high "pressed".
  // ---------------------------------------------------------------------
  logic [1:0]    sync1, sync2, acc, accept;
  logic [CW-1:0] db_cnt [2];

  always_comb begin
    accept = '0;
    for (int i = 0; i < 2; i++) begin
      accept[i] = ((~sync2[i]) != acc[i]) && (db_cnt[i] == DB_LAST);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1     <= 2'b11;
      sync2     <= 2'b11;
      acc       <= 2'b00;
      db_cnt[0] <= '0;
      db_cnt[1] <= '0;
    end else begin
      sync1 <= {btn_dir, btn_step};
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        if ((~sync2[i]) == acc[i]) begin
          db_cnt[i] <= '0;
        end else if (accept[i]) begin
          acc[i]    <= ~sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + CW'(1);
        end
      end
    end
  end

  // step_rise marks the cycle after the accepted step level goes pressed.
  // armed only sets once the synchronised button has been seen released
  // after reset, so a button already held at reset release never steps.
  // fill skips the first two cycles while the sync flops still hold their
  // reset value rather than the real pin level.
  logic       step_rise, armed, step;
  logic [1:0] fill;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      step_rise <= 1'b0;
      armed     <= 1'b0;
      fill      <= 2'd0;
    end else begin
      step_rise <= accept[0] & ~sync2[0];
      if (fill != 2'd2) fill <= fill + 2'd1;
      if ((fill == 2'd2) && !acc[0] && sync2[0]) armed <= 1'b1;
    end
  end

  assign step = step_rise & armed;

  // ---------------------------------------------------------------------
  // BCD arithmetic: ripple carry/borrow through every digit in one cycle.
  // acc[1] is the accepted direction (1 = down).
  // ---------------------------------------------------------------------
  logic [4*DIGITS-1:0] count_r, count_nxt;
  logic                wrap_r, cy, ovf;
  logic [3:0]          d;

  always_comb begin
    count_nxt = count_r;
    cy        = 1'b1;
    d         = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      d = count_r[4*i +: 4];
      if (cy) begin
        if (acc[1]) begin
          if (d == 4'd0) d = 4'd9;
          else begin
            d  = d - 4'd1;
            cy = 1'b0;
          end
        end else begin
          if (d == 4'd9) d = 4'd0;
          else begin
            d  = d + 4'd1;
            cy = 1'b0;
          end
        end
      end
      count_nxt[4*i +: 4] = d;
    end
    ovf = cy;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r <= '0;
      wrap_r  <= 1'b0;
    end else if (step) begin
      count_r <= count_nxt;
      wrap_r  <= ovf;
    end else begin
      wrap_r  <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Scan: prescaler 0..SCAN_DIV-1, index advances at terminal count.
  // ---------------------------------------------------------------------
  logic [PW-1:0] pre;
  logic [IW-1:0] idx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre <= '0;
      idx <= '0;
    end else if (pre == PRE_LAST) begin
      pre <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
    end else begin
      pre <= pre + PW'(1);
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'd0:    seg7 = 7'h3F;
      4'd1:    seg7 = 7'h06;
      4'd2:    seg7 = 7'h5B;
      4'd3:    seg7 = 7'h4F;
      4'd4:    seg7 = 7'h66;
      4'd5:    seg7 = 7'h6D;
      4'd6:    seg7 = 7'h7D;
      4'd7:    seg7 = 7'h07;
      4'd8:    seg7 = 7'h7F;
      4'd9:    seg7 = 7'h6F;
      default: seg7 = 7'h00;
    endcase
  endfunction

  // zero_from[i] = digit i and every digit above it are zero.
  logic [DIGITS-1:0] zero_from;
  logic              all_zero;

  always_comb begin
    zero_from = '0;
    all_zero  = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      all_zero     = all_zero & (count_r[4*i +: 4] == 4'd0);
      zero_from[i] = all_zero;
    end
  end

  // Active-high display image; pre == 0 is the anti-ghost blank cycle.
  logic [7:0]        seg_on;
  logic [DIGITS-1:0] dig_on;

  always_comb begin
    seg_on = '0;
    dig_on = '0;
    if (pre != '0) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (idx == IW'(i)) begin
          dig_on[i] = 1'b1;
          if (!((LZB != 0) && (i > 0) && zero_from[i])) begin
            seg_on[6:0] = seg7(count_r[4*i +: 4]);
          end
          // Decimal point on digit 0 flags down-count mode.
          if (i == 0) seg_on[7] = acc[1];
        end
      end
    end
  end

  assign seg   = (ACTIVE_LOW != 0) ? ~seg_on : seg_on;
  assign dig   = (ACTIVE_LOW != 0) ? ~dig_on : dig_on;
  assign count = count_r;
  assign wrap  = wrap_r;

endmodule
